sop_resp_checker: RTL

//  Response-side companion to the SoP stimulus sweep: accepts {input vector, DUT output} samples,

---
 rtl/sop_chk_pkg.sv | 22 ++
 rtl/sop_chk_misr.sv | 36 +++
 rtl/sop_resp_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sop_chk_pkg.sv
// Shared types and constants for the SoP response checker.
package sop_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int              MISR_W              = 8;
    localparam logic [MISR_W-1:0] MISR_POLY         = 8'h1D;
    localparam logic [15:0]     DEFAULT_TRUTH_TABLE = 16'hE8E8;

    // One MISR step: Galois shift with feedback polynomial, then fold in the data word.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                   input logic [MISR_W-1:0] din);
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? MISR_POLY : '0;
        return {sig[MISR_W-2:0], 1'b0} ^ fb ^ din;
    endfunction

endpackage

// File: rtl/sop_chk_misr.sv
// Signature register compressing every accepted {vector, output} sample.
module sop_chk_misr
    import sop_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q, sig_d;

    // Clear has priority over compression; otherwise hold.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_next(sig_q, din);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/sop_resp_checker.sv
// Response checker for the SoP stimulus sweep: compares samples against a golden
// truth table, tracks vector coverage, counts mismatches, captures the first failure.
// Optional build macro SOP_CHK_MISR_EN adds an 8-bit MISR signature output (misr_sig).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | after reset, waiting for start; results all zero
//  ST_RUN  | accepting samples; leaves when every vector has been seen
//  ST_DONE | coverage complete; results frozen until the next start
module sop_resp_checker
    import sop_chk_pkg::*;
#(
    parameter int                   N_IN        = 4,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int                   ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [N_IN-1:0]        in_vec,
    input  logic                   in_out,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [(1<<N_IN)-1:0]   cov_map,
    output logic                   first_fail_vld,
    output logic [N_IN-1:0]        first_fail_vec
`ifdef SOP_CHK_MISR_EN
    ,
    output logic [MISR_W-1:0]      misr_sig
`endif
);

    localparam int N_VEC = 1 << N_IN;

    state_e            state_q, state_d;
    logic [N_VEC-1:0]  cov_q, cov_d, cov_hit;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffvec_q, ffvec_d;
    logic              accept;
    logic              mismatch;

    // start always wins over a coincident sample, so it is excluded from accept.
    assign accept   = (state_q == ST_RUN) && in_valid && !start;
    assign mismatch = in_out != TRUTH_TABLE[in_vec];

    // One-hot of the vector currently presented.
    always_comb begin
        cov_hit         = '0;
        cov_hit[in_vec] = 1'b1;
    end

    // Next-state of the result registers: clear on start, update on accept.
    always_comb begin
        cov_d   = cov_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        if (start) begin
            cov_d   = '0;
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
        end else if (accept) begin
            cov_d = cov_q | cov_hit;
            if (mismatch) begin
                if (err_q != '1) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = in_vec;
                end
            end
        end
    end

    // FSM next-state; the accept that fills the map moves to DONE on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && (&(cov_q | cov_hit))) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cov_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            cov_q   <= cov_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign in_ready       = (state_q == ST_RUN);
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && (err_q == '0);
    assign err_cnt        = err_q;
    assign cov_map        = cov_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;

`ifdef SOP_CHK_MISR_EN
    logic [MISR_W-1:0] misr_din;

    assign misr_din = MISR_W'({in_vec, in_out});

    sop_chk_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (accept),
        .din   (misr_din),
        .sig   (misr_sig)
    );
`endif

endmodule
